// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ctrl_pkg
//  Description : Shared types and constants for the time-multiplexed 8-tap
//                FIR controller: FSM state encoding, default widths, sample
//                divider ratio, Q0.8 rounding constant and saturation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_ctrl_pkg;

    // Default configuration
    localparam int C_DATA_W = 8;
    localparam int C_TAPS   = 8;
    localparam int C_COEF_W = 8;
    localparam int C_ACC_W  = 20;
    localparam int C_DIV    = 10000;

    // Coefficients are Q0.8 (256 = 1.0), so products carry 8 fraction bits.
    localparam int C_FRAC_BITS   = 8;
    // Half an LSB of the output, added before the fraction bits are dropped.
    localparam int C_ROUND_CONST = 128;
    // Largest representable output sample for the default width.
    localparam int C_SAT_MAX     = (1 << C_DATA_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } fir_state_t;

endpackage : fir_ctrl_pkg
`default_nettype wire

// File: rtl/fir_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tick_gen
//  Description : Sample-rate divider. Counts 0..DIV-1 while i_enable is high
//                and emits a one-cycle o_tick on the last count. Dropping
//                i_enable clears the count, so the next tick comes a full
//                DIV cycles after i_enable returns high.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    sys_clk   in   clock, rising edge
//    reset_n   in   asynchronous active-low reset
//    i_enable  in   run the divider
//    o_tick    out  one-cycle sample strobe
// ============================================================================
module fir_tick_gen
    import fir_ctrl_pkg::*;
#(
    parameter int DIV = C_DIV
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int                 C_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DIV - 1);

    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (!i_enable) begin
            r_count <= '0;
        end else if (r_count == C_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && (r_count == C_LAST);

endmodule : fir_tick_gen
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer
//  Description : Time-multiplexed FIR controller. On each sample tick the new
//                sample is written into a circular history buffer, then one
//                shared multiplier accumulates buf[wr_ptr-k]*coef[k] over the
//                taps, the sum is rounded (Q0.8) and saturated, and filter_out
//                is updated with a one-cycle out_valid.
//  Revision    : 1.0 - initial release
//
//  Build option:
//    FIR_COEF_SYM_EN  symmetric taps: pairs of samples are pre-added and the
//                     MAC runs TAPS/2 cycles; the ROM holds the first half.
//
//  Ports:
//    sys_clk     in   clock, rising edge
//    reset_n     in   asynchronous active-low reset
//    enable      in   run the sample divider
//    sample_in   in   DATA_W sample, captured on the tick
//    coef_addr   out  tap index presented to the external coefficient ROM
//    coef_data   in   coefficient for coef_addr, same cycle
//    filter_out  out  filtered sample, held until the next update
//    out_valid   out  one-cycle pulse when filter_out updates
//    busy        out  high while a computation is in progress
//    overrun     out  one-cycle pulse, tick arrived while busy (sample dropped)
// ============================================================================
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int TAPS   = C_TAPS,
    parameter int COEF_W = C_COEF_W,
    parameter int ACC_W  = C_ACC_W,
    parameter int DIV    = C_DIV
) (
    input  logic                                   sys_clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [DATA_W-1:0]                      sample_in,
    output logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] coef_addr,
    input  logic [COEF_W-1:0]                      coef_data,
    output logic [DATA_W-1:0]                      filter_out,
    output logic                                   out_valid,
    output logic                                   busy,
    output logic                                   overrun
);

    localparam int C_PTR_W = (TAPS > 1) ? $clog2(TAPS) : 1;

`ifdef FIR_COEF_SYM_EN
    localparam int C_MAC_CYCLES = TAPS / 2;
    localparam int C_PRE_W      = DATA_W + 1;
`else
    localparam int C_MAC_CYCLES = TAPS;
    localparam int C_PRE_W      = DATA_W;
`endif

    localparam int                 C_PROD_W = C_PRE_W + COEF_W;
    localparam logic [C_PTR_W-1:0] C_K_LAST = C_PTR_W'(C_MAC_CYCLES - 1);

    fir_state_t          r_state;
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_PTR_W-1:0]  r_k;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_buf [TAPS];

    logic                w_tick;
    logic [C_PTR_W-1:0]  w_rd_idx;
    logic [C_PRE_W-1:0]  w_pre;
    logic [C_PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_acc_next;
    logic [ACC_W:0]      w_rounded;
    logic [ACC_W:0]      w_r;
    logic                w_ovf;
    logic [DATA_W-1:0]   w_sat;

    fir_tick_gen #(
        .DIV      (DIV)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    // Newest sample sits at wr_ptr; tap k reads the sample k ticks older.
    // PTR_W-bit arithmetic gives the modulo-TAPS wrap for free.
    assign w_rd_idx = r_wr_ptr - r_k;

`ifdef FIR_COEF_SYM_EN
    // Mirror tap TAPS-1-k: wr_ptr-(TAPS-1-k) == wr_ptr+k+1 modulo TAPS.
    logic [C_PTR_W-1:0] w_rd_idx_mirror;
    assign w_rd_idx_mirror = r_wr_ptr + r_k + 1'b1;
    assign w_pre = {1'b0, r_buf[w_rd_idx]} + {1'b0, r_buf[w_rd_idx_mirror]};
`else
    assign w_pre = r_buf[w_rd_idx];
`endif

    assign w_prod     = C_PROD_W'(w_pre) * C_PROD_W'(coef_data);
    assign w_acc_next = r_acc + ACC_W'(w_prod);

    // Round to nearest, drop the Q0.8 fraction, clamp to the output range.
    assign w_rounded = {1'b0, r_acc} + (ACC_W + 1)'(C_ROUND_CONST);
    assign w_r       = w_rounded >> C_FRAC_BITS;
    assign w_ovf     = |w_r[ACC_W:DATA_W];
    assign w_sat     = w_ovf ? {DATA_W{1'b1}} : w_r[DATA_W-1:0];

    assign coef_addr = r_k;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            filter_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_buf[r_wr_ptr] <= sample_in;
                        r_acc           <= '0;
                        r_k             <= '0;
                        busy            <= 1'b1;
                        r_state         <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    // A tick here is dropped; the running sum is unaffected.
                    overrun <= w_tick;
                    r_acc   <= w_acc_next;
                    if (r_k == C_K_LAST) begin
                        r_k     <= '0;
                        r_state <= ST_ROUND;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_ROUND: begin
                    // Still busy this cycle, so a coincident tick is dropped too.
                    overrun    <= w_tick;
                    filter_out <= w_sat;
                    out_valid  <= 1'b1;
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    busy       <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fir_mac_sequencer
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_sequencer
//  Description : Directed, table-driven bench for fir_mac_sequencer. DUT A
//                runs with DIV=20 (no overruns possible); DUT B runs with a
//                short divider so ticks land during the MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int DIV_A = 20;
`ifdef FIR_COEF_SYM_EN
    localparam int LAT     = 6;
    localparam int MACN    = 4;
    localparam int OVR_DIV = 4;
`else
    localparam int LAT     = 10;
    localparam int MACN    = 8;
    localparam int OVR_DIV = 8;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       enable, enable_b;
    logic [7:0] sample_in, sample_b;
    logic [7:0] rom [8];
    logic [2:0] coef_addr, coef_addr_b;
    logic [7:0] coef_data, coef_data_b;
    logic [7:0] filter_out, filter_out_b;
    logic       out_valid, out_valid_b;
    logic       busy, busy_b;
    logic       overrun, overrun_b;

    assign coef_data   = rom[coef_addr];
    assign coef_data_b = rom[coef_addr_b];

    fir_mac_sequencer #(.DIV(DIV_A)) u_dut (
        .sys_clk    (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .sample_in  (sample_in),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .filter_out (filter_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    fir_mac_sequencer #(.DIV(OVR_DIV)) u_dut_ovr (
        .sys_clk    (clk),
        .reset_n    (reset_n),
        .enable     (enable_b),
        .sample_in  (sample_b),
        .coef_addr  (coef_addr_b),
        .coef_data  (coef_data_b),
        .filter_out (filter_out_b),
        .out_valid  (out_valid_b),
        .busy       (busy_b),
        .overrun    (overrun_b)
    );

    // Reference divider for DUT A: records the cycle of the latest tick.
    int cyc       = 0;
    int m_cnt     = 0;
    int last_tick = -1000;
    always @(posedge clk) begin
        if (!reset_n || !enable) begin
            m_cnt <= 0;
        end else if (m_cnt == DIV_A - 1) begin
            m_cnt     <= 0;
            last_tick <= cyc;
        end else begin
            m_cnt <= m_cnt + 1;
        end
        cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input int kind);
        for (int i = 0; i < 8; i++) begin
            case (kind)
                1:       rom[i] = 8'd64;
                2:       rom[i] = 8'(16 * (i + 1));
                default: rom[i] = 8'd32;
            endcase
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        enable_b = 1'b0;
        step();
        step();
        check("rst_filter_out", 32'(filter_out), 0);
        check("rst_valid_busy_ovr", {29'd0, out_valid, busy, overrun}, 0);
        check("rst_coef_addr", 32'(coef_addr), 0);
        reset_n = 1'b1;
        step();
        enable = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * DIV_A + LAT; i++) begin
            step();
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * DIV_A; i++) begin
            step();
            if (last_tick == cyc - 1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        bit         rst;
        int         rom_kind;
        logic [7:0] sample;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input int k, input logic [7:0] s, input logic [7:0] e);
        vec_t v;
        v.rst = r; v.rom_kind = k; v.sample = s; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        bit ok;
        int e_cyc;
        int n_valid;
        int n_out;
        int rel;
        int a0, a1;
        logic [7:0] ramp_exp [8];
        logic [7:0] vals_b [2];

        reset_n   = 1'b0;
        enable    = 1'b0;
        enable_b  = 1'b0;
        sample_in = '0;
        sample_b  = '0;
        set_rom(0);

        // Impulse, uniform coefficients 32: eight outputs of 32, then 0.
        add(1, 0, 8'd255, 8'd32);
        for (int i = 0; i < 7; i++) add(0, 0, 8'd0, 8'd32);
        add(0, 0, 8'd0, 8'd0);
        // DC 200, coefficients 32: ramp 25n, then steady 200.
        add(1, 0, 8'd200, 8'd25);
        for (int n = 2; n <= 8; n++) add(0, 0, 8'd200, 8'(25 * n));
        add(0, 0, 8'd200, 8'd200);
        // DC 200, coefficients 64: 50n, clamped at 255.
        add(1, 1, 8'd200, 8'd50);
        add(0, 1, 8'd200, 8'd100);
        add(0, 1, 8'd200, 8'd150);
        add(0, 1, 8'd200, 8'd200);
        add(0, 1, 8'd200, 8'd250);
        add(0, 1, 8'd200, 8'd255);
        add(0, 1, 8'd200, 8'd255);
        add(0, 1, 8'd200, 8'd255);
        // Impulse through ramp coefficients 16*(k+1): reads out the tap order.
`ifdef FIR_COEF_SYM_EN
        ramp_exp = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd64, 8'd48, 8'd32, 8'd16};
`else
        ramp_exp = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112, 8'd128};
`endif
        add(1, 2, 8'd255, ramp_exp[0]);
        for (int i = 1; i < 8; i++) add(0, 2, 8'd0, ramp_exp[i]);
        add(0, 2, 8'd0, 8'd0);

        foreach (vecs[i]) begin
            set_rom(vecs[i].rom_kind);
            sample_in = vecs[i].sample;
            if (vecs[i].rst) do_reset();
            wait_valid(ok);
            if (!ok) begin
                check($sformatf("vec%0d_timeout", i), 0, 1);
            end else begin
                check($sformatf("vec%0d_out", i), 32'(filter_out), 32'(vecs[i].exp));
                check($sformatf("vec%0d_latency", i), 32'(cyc - last_tick), LAT);
                check($sformatf("vec%0d_busy_at_valid", i), 32'(busy), 0);
                step();
                check($sformatf("vec%0d_valid_pulse", i), 32'(out_valid), 0);
            end
        end

        // Reset in the middle of the MAC, then constant 100 from a clean buffer.
        set_rom(0);
        sample_in = 8'd200;
        do_reset();
        wait_valid(ok);
        check("prerst_out", ok ? 32'(filter_out) : 32'hFFFF, 25);
        wait_tick(ok);
        check("prerst_tick_seen", 32'(ok), 1);
        step(); step(); step();
        check("midmac_coef_addr", 32'(coef_addr), 3);
        check("midmac_busy", 32'(busy), 1);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check("async_rst_out", 32'(filter_out), 0);
        check("async_rst_busy_addr", {28'd0, busy, coef_addr}, 0);
        step();
        step();
        sample_in = 8'd100;
        reset_n   = 1'b1;
        enable    = 1'b1;
        e_cyc     = cyc;
        for (int n = 0; n < 3; n++) begin
            wait_valid(ok);
            if (!ok) begin
                check($sformatf("postrst%0d_timeout", n), 0, 1);
            end else begin
                if (n == 0) check("postrst_first_arrival", 32'(cyc - e_cyc), DIV_A - 1 + LAT);
                check($sformatf("postrst%0d_out", n), 32'(filter_out),
                      (n == 0) ? 13 : (n == 1) ? 25 : 38);
            end
        end

        // Enable dropped right after a tick: that result still arrives.
        wait_tick(ok);
        check("en_tick_seen", 32'(ok), 1);
        enable = 1'b0;
        wait_valid(ok);
        check("en_low_out", ok ? 32'(filter_out) : 32'hFFFF, 50);
        check("en_low_latency", 32'(cyc - last_tick), LAT);
        n_valid = 0;
        for (int i = 0; i < 3 * DIV_A; i++) begin
            step();
            if (out_valid || busy) n_valid++;
        end
        check("en_low_quiet", 32'(n_valid), 0);
        enable = 1'b1;
        e_cyc  = cyc;
        wait_valid(ok);
        check("en_restart_arrival", ok ? 32'(cyc - e_cyc) : 32'hFFFF, DIV_A - 1 + LAT);
        check("en_restart_out", 32'(filter_out), 63);

        // Overrun on DUT B: every second tick lands while busy and is dropped.
        set_rom(0);
        sample_b = 8'd100;
        do_reset();
        enable   = 1'b0;
        enable_b = 1'b1;
        e_cyc    = cyc;
        a0       = OVR_DIV - 1;
        a1       = 3 * OVR_DIV - 1;
        vals_b   = '{8'd13, 8'd25};
        n_out    = 0;
        for (int i = 0; i <= 4 * OVR_DIV + 2; i++) begin
            bit exp_busy, exp_valid, exp_ovr;
            if (i > 0) step();
            rel       = cyc - e_cyc;
            exp_busy  = (rel >= a0 + 1 && rel <= a0 + MACN + 1) ||
                        (rel >= a1 + 1 && rel <= a1 + MACN + 1);
            exp_valid = (rel == a0 + MACN + 2) || (rel == a1 + MACN + 2);
            exp_ovr   = (rel == a0 + OVR_DIV + 1) || (rel == a1 + OVR_DIV + 1);
            check($sformatf("ovr_busy@%0d", rel), 32'(busy_b), 32'(exp_busy));
            check($sformatf("ovr_valid@%0d", rel), 32'(out_valid_b), 32'(exp_valid));
            check($sformatf("ovr_pulse@%0d", rel), 32'(overrun_b), 32'(exp_ovr));
            if (exp_valid && n_out < 2) begin
                check($sformatf("ovr_out%0d", n_out), 32'(filter_out_b), 32'(vals_b[n_out]));
                n_out++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fir_mac_sequencer
`default_nettype wire
